// File: rtl/afifo_wr_serializer.sv
// Write-side feeder for the async FIFO: splits WIDTH*RATIO words into RATIO slices, LS first.
// Optional stall statistics counter enabled by defining AFIFO_WR_STATS_EN.
module afifo_wr_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
`ifdef AFIFO_WR_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                   wclk,
  input  logic                   wrstn,
  input  logic                   clr,
  input  logic                   s_valid,
  input  logic [WIDTH*RATIO-1:0] s_data,
  output logic                   s_ready,
  input  logic                   wfull,
  output logic                   winc,
  output logic [WIDTH-1:0]       wdata,
  output logic                   busy
`ifdef AFIFO_WR_STATS_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(RATIO);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                        state;
  logic   [IdxW-1:0]             idx;
  logic   [RATIO-1:0][WIDTH-1:0] hold;
  logic                          last;

  assign last    = (idx == IdxW'(RATIO - 1));
  assign wdata   = hold[idx];
  assign busy    = (state == StShift);
  assign winc    = (state == StShift) && !wfull && !clr;
  // Taking a new word while the last slice leaves gives back-to-back words with no bubble.
  assign s_ready = !clr && ((state == StIdle) || (last && winc));

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state <= StIdle;
      idx   <= '0;
      hold  <= '0;
    end else if (clr) begin
      state <= StIdle;
      idx   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (s_valid && s_ready) begin
            hold  <= s_data;
            idx   <= '0;
            state <= StShift;
          end
        end
        StShift: begin
          if (winc) begin
            if (!last) begin
              idx <= idx + IdxW'(1);
            end else if (s_valid) begin
              hold <= s_data;
              idx  <= '0;
            end else begin
              idx   <= '0;
              state <= StIdle;
            end
          end
        end
        default: begin
          state <= StIdle;
          idx   <= '0;
        end
      endcase
    end
  end

`ifdef AFIFO_WR_STATS_EN
  // Counts blocked cycles; only the async reset clears it, clr leaves it intact.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      stall_cnt <= '0;
    end else if ((state == StShift) && wfull && !clr && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_afifo_wr_serializer.sv
// Directed self-checking bench for afifo_wr_serializer (WIDTH=8, RATIO=4).
// Stall counter checks apply when AFIFO_WR_STATS_EN is defined (CNT_W=4).
module tb_afifo_wr_serializer;

  logic        wclk;
  logic        wrstn;
  logic        clr;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
`ifdef AFIFO_WR_STATS_EN
  logic [3:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  afifo_wr_serializer #(
    .WIDTH(8),
    .RATIO(4)
`ifdef AFIFO_WR_STATS_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .wclk     (wclk),
    .wrstn    (wrstn),
    .clr      (clr),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy)
`ifdef AFIFO_WR_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Let combinational outputs settle on the current inputs, then compare.
  task automatic cyc(input string tag, input logic ew, input logic [7:0] ed, input logic er,
                     input logic eb);
    #1;
    chk({tag, ".winc"}, {31'd0, winc}, {31'd0, ew});
    chk({tag, ".wdata"}, {24'd0, wdata}, {24'd0, ed});
    chk({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, er});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".no_winc_when_full"}, {31'd0, winc & wfull}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp_b;
    wrstn   = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'd0;
    wfull   = 1'b0;
    #2;
    cyc("reset", 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef AFIFO_WR_STATS_EN
    chk("reset.stall_cnt", {28'd0, stall_cnt}, 32'd0);
`endif
    #10;
    wrstn = 1'b1;

    // Single word
    tick();
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    cyc("single.accept", 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    cyc("single.s0", 1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    cyc("single.s1", 1'b1, 8'h22, 1'b0, 1'b1);
    tick();
    cyc("single.s2", 1'b1, 8'h33, 1'b0, 1'b1);
    tick();
    cyc("single.s3", 1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    cyc("single.done", 1'b0, 8'h11, 1'b1, 1'b0);

    // Back-to-back words with s_valid held
    s_valid = 1'b1;
    s_data  = 32'hA3A2A1A0;
    cyc("b2b.accept", 1'b0, 8'h11, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      s_data  = 32'hB3B2B1B0;
      s_valid = (i < 7);
      exp_b   = (i < 4) ? (8'hA0 + 8'(i)) : (8'hB0 + 8'(i - 4));
      cyc($sformatf("b2b.s%0d", i), 1'b1, exp_b, (i == 3) || (i == 7), 1'b1);
    end
    tick();
    cyc("b2b.done", 1'b0, 8'hB0, 1'b1, 1'b0);

    // Backpressure on slice 0x33
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    cyc("bp.accept", 1'b0, 8'hB0, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    cyc("bp.s0", 1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    cyc("bp.s1", 1'b1, 8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      wfull = 1'b1;
      cyc($sformatf("bp.stall%0d", i), 1'b0, 8'h33, 1'b0, 1'b1);
    end
    tick();
    wfull = 1'b0;
    cyc("bp.s2", 1'b1, 8'h33, 1'b0, 1'b1);
`ifdef AFIFO_WR_STATS_EN
    chk("bp.stall_cnt", {28'd0, stall_cnt}, 32'd3);
`endif
    tick();
    cyc("bp.s3", 1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    cyc("bp.done", 1'b0, 8'h11, 1'b1, 1'b0);

    // Abort after two slices, then a fresh word
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    cyc("clr.accept", 1'b0, 8'h11, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    cyc("clr.s0", 1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    cyc("clr.s1", 1'b1, 8'h22, 1'b0, 1'b1);
    tick();
    clr = 1'b1;
    cyc("clr.pulse", 1'b0, 8'h33, 1'b0, 1'b1);
    tick();
    clr     = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h88776655;
    cyc("clr.after", 1'b0, 8'h11, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    cyc("clr.n0", 1'b1, 8'h55, 1'b0, 1'b1);
    tick();
    cyc("clr.n1", 1'b1, 8'h66, 1'b0, 1'b1);
    tick();
    cyc("clr.n2", 1'b1, 8'h77, 1'b0, 1'b1);
    tick();
    cyc("clr.n3", 1'b1, 8'h88, 1'b1, 1'b1);
    tick();
    cyc("clr.done", 1'b0, 8'h55, 1'b1, 1'b0);

    // Reset mid-word
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    cyc("rst.accept", 1'b0, 8'h55, 1'b1, 1'b0);
    tick();
    s_valid = 1'b0;
    cyc("rst.s0", 1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    cyc("rst.s1", 1'b1, 8'h22, 1'b0, 1'b1);
    wrstn = 1'b0;
    cyc("rst.async", 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef AFIFO_WR_STATS_EN
    chk("rst.stall_cnt", {28'd0, stall_cnt}, 32'd0);
`endif
    @(negedge wclk);
    wrstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc($sformatf("rst.quiet%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
    end

`ifdef AFIFO_WR_STATS_EN
    // Stall counter saturation
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    cyc("sat.accept", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      s_valid = 1'b0;
      wfull   = 1'b1;
      cyc($sformatf("sat.stall%0d", i), 1'b0, 8'h11, 1'b0, 1'b1);
      chk($sformatf("sat.cnt%0d", i), {28'd0, stall_cnt}, (i < 15) ? 32'(i) : 32'd15);
    end
    tick();
    wfull = 1'b0;
    cyc("sat.s0", 1'b1, 8'h11, 1'b0, 1'b1);
    chk("sat.cnt_hold", {28'd0, stall_cnt}, 32'd15);
    tick();
    cyc("sat.s1", 1'b1, 8'h22, 1'b0, 1'b1);
    tick();
    cyc("sat.s2", 1'b1, 8'h33, 1'b0, 1'b1);
    tick();
    cyc("sat.s3", 1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    cyc("sat.done", 1'b0, 8'h11, 1'b1, 1'b0);
    chk("sat.cnt_final", {28'd0, stall_cnt}, 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/afifo_wr_serializer.md
# afifo_wr_serializer

Write-side feeder for the team's asynchronous FIFO, in the `wclk` domain. It accepts wide words on a valid/ready stream and splits each word into RATIO FIFO-width slices, least-significant slice first. It drives `winc`/`wdata` into the FIFO write port and obeys `wfull` backpressure, so no slice is ever dropped or duplicated. It is the producer counterpart to the FIFO read logic.

## Interface
- WIDTH, 8, FIFO data width; width of one slice.
- RATIO, 4, slices per input word; must be ≥2.
- CNT_W, 16, width of the stall counter (only when `AFIFO_WR_STATS_EN` is defined).

Ports:
- wclk  in  1  write-domain clock; all state updates on rising edge.
- wrstn  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort of the word in flight; highest priority after reset.
- s_valid  in  1  input word valid.
- s_data  in  WIDTH*RATIO  input word.
- s_ready  out  1  input word accepted on an edge where s_valid && s_ready.
- wfull  in  1  FIFO full flag, already synchronised to `wclk`.
- winc  out  1  FIFO write strobe.
- wdata  out  WIDTH  FIFO write data.
- busy  out  1  a word is held and not yet fully written.
- stall_cnt  out  CNT_W  saturating count of blocked cycles (only with the macro).

## Operation
- Registers:
  - `state` ∈ {IDLE, SHIFT}.
  - `idx`, $clog2(RATIO) bits.
  - `hold`, WIDTH*RATIO bits.
- Reset values: state=IDLE, idx=0, hold=0, stall_cnt=0.
- Outputs during reset: s_ready=1, winc=0, wdata=0, busy=0.
- Combinational outputs:
  - `wdata = hold[idx*WIDTH +: WIDTH]`.
  - `winc = (state==SHIFT) && !wfull && !clr`.
  - `busy = (state==SHIFT)`.
  - `last = (idx==RATIO-1)`.
  - `s_ready = !clr && ((state==IDLE) || (last && winc))`.
- IDLE:
  - On s_valid && s_ready: hold ← s_data, idx ← 0, state ← SHIFT.
  - Otherwise remain in IDLE.
- SHIFT:
  - winc=1 and !last: idx ← idx+1.
  - winc=1 and last, with s_valid: hold ← s_data, idx ← 0, stay in SHIFT. This is the back-to-back case with no bubble.
  - winc=1 and last, without s_valid: idx ← 0, state ← IDLE.
  - winc=0 (wfull high): hold, idx and state are frozen, and wdata holds its value.
- clr=1, in any state:
  - Next state is IDLE with idx ← 0. hold is retained but is don't-care.
  - In that same cycle winc=0 and s_ready=0.
  - Remaining slices of the held word are discarded.
- Reset asserted mid-word: the word is lost, and outputs take their reset values immediately (asynchronously).
- The FIFO itself also gates writes with !wfull. This block must still never assert winc while wfull=1.

## Timing
- A word accepted at edge N has its first slice presented with winc=1 during cycle N+1, provided wfull=0.
- With no backpressure, slices occupy cycles N+1 … N+RATIO.
- Sustained throughput is one slice per cycle, i.e. one word per RATIO cycles. With continuous s_valid there is no idle cycle between words.
- Each wfull=1 cycle while in SHIFT adds exactly one cycle of latency.
- The s_ready path is combinational from wfull and clr. Upstream must not make s_valid depend combinationally on s_ready.
- A wfull rise in the same cycle as the last slice blocks that slice. s_ready then stays 0 until the slice is written.

## Configuration
- `AFIFO_WR_STATS_EN` defined:
  - `stall_cnt` port exists.
  - It increments on every cycle with state==SHIFT && wfull && !clr.
  - It saturates at all-ones.
  - It is cleared only by wrstn; clr does not clear it.
- `AFIFO_WR_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
Defaults WIDTH=8, RATIO=4 unless noted.
- Single word: s_data=0x44332211 accepted at edge N, wfull=0 → winc=1 in cycles N+1..N+4 with wdata 0x11, 0x22, 0x33, 0x44. s_ready=1 in cycle N+4, busy=0 at N+5.
- Back-to-back: s_valid held with 0xA3A2A1A0 then 0xB3B2B1B0 → 8 consecutive winc cycles carrying A0 A1 A2 A3 B0 B1 B2 B3 with no gap.
- Backpressure: wfull=1 for 3 cycles while wdata=0x33 → winc=0 and wdata=0x33 held for those 3 cycles; then 0x33 and 0x44 are written. stall_cnt=3 (macro on). No winc while wfull=1, checked by assertion.
- Abort: clr pulsed after slices 0x11 and 0x22 are written → no further winc, busy=0 next cycle, s_ready=1 next cycle. A following word 0x88776655 emits 0x55 first.
- Reset mid-word: wrstn low after one slice → winc=0, busy=0, s_ready=1 immediately; after release no stale slices appear.
- Saturation: CNT_W=4, macro on, wfull held 20 cycles in SHIFT → stall_cnt=15 and stays 15.
